// File: rtl/mem_sim_port.sv
// rtl/mem_sim_port.sv - wait-state memory responder with byte strobes, console FIFO, exit register and error flag
// Optional feature macro MEMSIM_RANDOM_STALL_EN: LFSR-driven extra wait cycles per transaction.
module mem_sim_port #(
    parameter int          MEM_WORDS    = 65536,
    parameter int          WAIT_STATES  = 1,
    parameter logic [31:0] CONSOLE_ADDR = 32'h1000_0000,
    parameter logic [31:0] EXIT_ADDR    = 32'h2000_0000,
    parameter int          FIFO_DEPTH   = 8
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        mem_valid,
    input  logic        mem_instr,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic        mem_ready,
    output logic [31:0] mem_rdata,
    output logic [7:0]  con_data,
    output logic        con_valid,
    input  logic        con_ready,
    output logic        exit_valid,
    output logic [31:0] exit_code,
    output logic        err,
    output logic [31:0] fetch_count
);

    localparam int MW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam int FA = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [FA:0] PTR_ONE = 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d, cnt_load;
    logic [29:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;
    logic        instr_q;

    logic [29:0] req_addr;
    logic [3:0]  req_wstrb;
    logic        req_con, req_exit, req_in_range, req_read, req_con_push;
    logic        enter_resp;

    logic [31:0] storage [MEM_WORDS];
    logic [7:0]  fifo_mem [FIFO_DEPTH];
    logic [FA:0] wr_ptr, rd_ptr;
    logic        fifo_full, con_pop, fifo_push, resp_block;
    logic        unused_bits;

    assign unused_bits = ^mem_addr[1:0];

    // In IDLE the request is decoded straight from the bus, afterwards from the latched copy.
    assign req_addr     = (state_q == S_IDLE) ? mem_addr[31:2] : addr_q;
    assign req_wstrb    = (state_q == S_IDLE) ? mem_wstrb : wstrb_q;
    assign req_con      = (req_addr == CONSOLE_ADDR[31:2]);
    assign req_exit     = (req_addr == EXIT_ADDR[31:2]);
    assign req_in_range = ({2'b00, req_addr} < 32'(MEM_WORDS));
    assign req_read     = (req_wstrb == 4'h0);
    assign req_con_push = req_con && req_wstrb[0];

    assign con_valid = (wr_ptr != rd_ptr);
    assign fifo_full = (wr_ptr[FA] != rd_ptr[FA]) && (wr_ptr[FA-1:0] == rd_ptr[FA-1:0]);
    assign con_pop   = con_valid && con_ready;
    assign con_data  = con_valid ? fifo_mem[rd_ptr[FA-1:0]] : 8'h00;
    assign fifo_push = (state_q == S_RESP) && req_con_push;

    // A same-cycle pop frees the slot before RESP pushes, so only a post-pop full blocks.
    assign resp_block = req_con_push && fifo_full && !con_pop;

`ifdef MEMSIM_RANDOM_STALL_EN
    logic [15:0] lfsr_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            lfsr_q <= 16'hACE1;
        end else begin
            lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        end
    end

    assign cnt_load = 5'(WAIT_STATES) + {3'b000, lfsr_q[1:0]};
`else
    assign cnt_load = 5'(WAIT_STATES);
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        mem_ready  = 1'b0;
        enter_resp = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (mem_valid) begin
                    cnt_d = cnt_load;
                    if (cnt_load == 5'd0 && !resp_block) begin
                        state_d    = S_RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q <= 5'd1) begin
                    if (!resp_block) begin
                        state_d    = S_RESP;
                        enter_resp = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 5'd1;
                end
            end
            S_RESP: begin
                mem_ready = 1'b1;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= S_IDLE;
            cnt_q       <= 5'd0;
            addr_q      <= 30'd0;
            wdata_q     <= 32'd0;
            wstrb_q     <= 4'h0;
            instr_q     <= 1'b0;
            mem_rdata   <= 32'd0;
            exit_valid  <= 1'b0;
            exit_code   <= 32'd0;
            err         <= 1'b0;
            fetch_count <= 32'd0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (state_q == S_IDLE && mem_valid) begin
                addr_q  <= mem_addr[31:2];
                wdata_q <= mem_wdata;
                wstrb_q <= mem_wstrb;
                instr_q <= mem_instr;
            end
            if (enter_resp && req_read) begin
                if (req_con || req_exit) begin
                    mem_rdata <= 32'd0;
                end else if (req_in_range) begin
                    mem_rdata <= storage[req_addr[MW-1:0]];
                end else begin
                    mem_rdata <= 32'hDEAD_BEEF;
                end
            end
            if (state_q == S_RESP) begin
                if (!req_con && !req_exit && !req_in_range) begin
                    err <= 1'b1;
                end
                if (req_exit && wstrb_q != 4'h0) begin
                    exit_valid <= 1'b1;
                    exit_code  <= wdata_q;
                end
                if (instr_q && wstrb_q == 4'h0) begin
                    fetch_count <= fetch_count + 32'd1;
                end
            end
            if (fifo_push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (con_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

    // Storage and FIFO data are plain RAMs without reset; commits happen only in RESP.
    always_ff @(posedge clk) begin
        if (state_q == S_RESP && req_in_range && !req_con && !req_exit) begin
            for (int i = 0; i < 4; i++) begin
                if (wstrb_q[i]) begin
                    storage[addr_q[MW-1:0]][8*i +: 8] <= wdata_q[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (fifo_push) begin
            fifo_mem[wr_ptr[FA-1:0]] <= wdata_q[7:0];
        end
    end

endmodule

// File: tb/tb_mem_sim_port.sv
// tb/tb_mem_sim_port.sv - randomized self-checking bench for mem_sim_port against a queue/array reference model
module tb_mem_sim_port;

    localparam int          MEM_WORDS = 1024;
    localparam int          WS        = 2;
    localparam int          FD        = 8;
    localparam logic [31:0] CON       = 32'h1000_0000;
    localparam logic [31:0] EXA       = 32'h2000_0000;

    logic        clk;
    logic        resetn;
    logic        mem_valid;
    logic        mem_instr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic [7:0]  con_data;
    logic        con_valid;
    logic        con_ready;
    logic        exit_valid;
    logic [31:0] exit_code;
    logic        err;
    logic [31:0] fetch_count;

    mem_sim_port #(
        .MEM_WORDS   (MEM_WORDS),
        .WAIT_STATES (WS),
        .CONSOLE_ADDR(CON),
        .EXIT_ADDR   (EXA),
        .FIFO_DEPTH  (FD)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .mem_valid  (mem_valid),
        .mem_instr  (mem_instr),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wstrb  (mem_wstrb),
        .mem_ready  (mem_ready),
        .mem_rdata  (mem_rdata),
        .con_data   (con_data),
        .con_valid  (con_valid),
        .con_ready  (con_ready),
        .exit_valid (exit_valid),
        .exit_code  (exit_code),
        .err        (err),
        .fetch_count(fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model: word array, console byte queue, scalar flags.
    logic [31:0] ref_mem [int];
    logic [7:0]  con_q [$];
    logic        ref_exit_valid = 1'b0;
    logic [31:0] ref_exit_code  = 32'd0;
    logic        ref_err        = 1'b0;
    logic [31:0] ref_fetch      = 32'd0;

    function automatic void ref_apply(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
                                      input logic ins, output logic [31:0] exp_rd, output bit rd_known);
        int unsigned w;
        logic [31:0] base;
        w        = a >> 2;
        exp_rd   = 32'd0;
        rd_known = 1'b1;
        if (w == (CON >> 2)) begin
            if (ws != 4'h0 && ws[0]) con_q.push_back(wd[7:0]);
        end else if (w == (EXA >> 2)) begin
            if (ws != 4'h0) begin
                ref_exit_valid = 1'b1;
                ref_exit_code  = wd;
            end
        end else if (w < MEM_WORDS) begin
            if (ws == 4'h0) begin
                if (ref_mem.exists(w)) exp_rd = ref_mem[w];
                else rd_known = 1'b0;
            end else if (ref_mem.exists(w) || ws == 4'hF) begin
                base = ref_mem.exists(w) ? ref_mem[w] : 32'd0;
                for (int b = 0; b < 4; b++) if (ws[b]) base[8*b +: 8] = wd[8*b +: 8];
                ref_mem[w] = base;
            end
        end else begin
            ref_err = 1'b1;
            exp_rd  = 32'hDEAD_BEEF;
        end
        if (ins && ws == 4'h0) ref_fetch = ref_fetch + 32'd1;
    endfunction

    // Console consumer: 0 = stalled, 1 = always ready, 2 = random back-pressure.
    int con_mode = 0;
    always @(negedge clk) begin
        case (con_mode)
            0:       con_ready = 1'b0;
            1:       con_ready = 1'b1;
            default: con_ready = 1'($urandom_range(0, 1));
        endcase
        if (resetn && con_valid && con_ready) begin
            if (con_q.size() == 0) check("con_queue_nonempty", 32'(con_q.size()), 32'd1);
            else check("con_byte", {24'h0, con_data}, {24'h0, con_q.pop_front()});
        end
    end

    int ready_pulses = 0;
    always @(negedge clk) if (mem_ready === 1'b1) ready_pulses++;

    task automatic drive(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws, input logic ins);
        mem_addr  = a;
        mem_wdata = wd;
        mem_wstrb = ws;
        mem_instr = ins;
        mem_valid = 1'b1;
    endtask

    task automatic wait_ready(input int budget, output bit done, output int lat, output logic [31:0] rd);
        done = 1'b0;
        lat  = 0;
        rd   = 32'd0;
        while (!done && lat < budget) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (mem_ready === 1'b1) begin
                done = 1'b1;
                rd   = mem_rdata;
            end
        end
        if (done) begin
            mem_valid = 1'b0;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic txn(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws, input logic ins,
                       output logic [31:0] rd, output int lat, output logic [31:0] exp_rd, output bit rd_known);
        bit done;
        drive(a, wd, ws, ins);
        wait_ready(200, done, lat, rd);
        check("txn_done", 32'(done), 32'd1);
        if (!done) mem_valid = 1'b0;
        ref_apply(a, wd, ws, ins, exp_rd, rd_known);
    endtask

    task automatic check_reset(input string p);
        check({p, "_mem_ready"},   32'(mem_ready),   32'd0);
        check({p, "_mem_rdata"},   mem_rdata,        32'd0);
        check({p, "_con_valid"},   32'(con_valid),   32'd0);
        check({p, "_con_data"},    {24'h0, con_data}, 32'd0);
        check({p, "_exit_valid"},  32'(exit_valid),  32'd0);
        check({p, "_exit_code"},   exit_code,        32'd0);
        check({p, "_err"},         32'(err),         32'd0);
        check({p, "_fetch_count"}, fetch_count,      32'd0);
    endtask

    task automatic wait_drain(input string tag);
        int guard = 0;
        while (con_q.size() != 0 && guard < 500) begin
            @(posedge clk);
            guard++;
        end
        @(negedge clk);
        check({tag, "_model_empty"}, 32'(con_q.size()), 32'd0);
        check({tag, "_con_valid"},   32'(con_valid),    32'd0);
    endtask

    initial begin
        logic [31:0] rd, exp_rd;
        int          lat, p0, kind;
        bit          known, done;
        logic [31:0] a, wd;
        logic [3:0]  ws;
        logic        ins;

        resetn    = 1'b0;
        mem_valid = 1'b0;
        mem_instr = 1'b0;
        mem_addr  = 32'd0;
        mem_wdata = 32'd0;
        mem_wstrb = 4'h0;
        repeat (3) @(posedge clk);
        #1;
        check_reset("por");
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;

        // Basic write/read with latency WAIT_STATES+1.
        txn(32'h100, 32'h1234_5678, 4'hF, 1'b0, rd, lat, exp_rd, known);
        check("wr_latency", 32'(lat), 32'(WS + 1));
        txn(32'h100, 32'd0, 4'h0, 1'b0, rd, lat, exp_rd, known);
        check("rd_latency", 32'(lat), 32'(WS + 1));
        check("rd_0x100", rd, 32'h1234_5678);

        // Byte strobes.
        txn(32'h200, 32'd0, 4'hF, 1'b0, rd, lat, exp_rd, known);
        txn(32'h200, 32'hAABB_CCDD, 4'b0101, 1'b0, rd, lat, exp_rd, known);
        txn(32'h200, 32'd0, 4'h0, 1'b0, rd, lat, exp_rd, known);
        check("strobe_0x200", rd, 32'h00BB_00DD);

        // Console back-pressure: 8 fit, the 9th stalls until the consumer pops.
        con_mode = 0;
        for (int i = 0; i < FD; i++) begin
            txn(CON, 32'h41 + i, 4'h1, 1'b0, rd, lat, exp_rd, known);
        end
        drive(CON, 32'h49, 4'h1, 1'b0);
        wait_ready(20, done, lat, rd);
        check("con_9th_stalled", 32'(done), 32'd0);
        con_mode = 1;
        wait_ready(100, done, lat, rd);
        check("con_9th_done", 32'(done), 32'd1);
        if (!done) mem_valid = 1'b0;
        ref_apply(CON, 32'h49, 4'h1, 1'b0, exp_rd, known);
        wait_drain("con_drain");
        check("err_after_console", 32'(err), 32'd0);

        // Exit register and out-of-range error.
        txn(EXA, 32'h0000_002A, 4'hF, 1'b0, rd, lat, exp_rd, known);
        check("exit_valid", 32'(exit_valid), 32'd1);
        check("exit_code", exit_code, 32'd42);
        txn(EXA, 32'd0, 4'h0, 1'b0, rd, lat, exp_rd, known);
        check("exit_read_zero", rd, 32'd0);
        txn(MEM_WORDS * 4, 32'd0, 4'h0, 1'b0, rd, lat, exp_rd, known);
        check("oor_rdata", rd, 32'hDEAD_BEEF);
        check("oor_err", 32'(err), 32'd1);

        // Reset in the middle of a write.
        txn(32'h300, 32'h1111_1111, 4'hF, 1'b0, rd, lat, exp_rd, known);
        p0 = ready_pulses;
        drive(32'h300, 32'hFFFF_FFFF, 4'hF, 1'b0);
        @(posedge clk);
        @(negedge clk);
        resetn    = 1'b0;
        mem_valid = 1'b0;
        #1;
        check_reset("midreset");
        ref_exit_valid = 1'b0;
        ref_exit_code  = 32'd0;
        ref_err        = 1'b0;
        ref_fetch      = 32'd0;
        con_q.delete();
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("no_ready_on_abort", 32'(ready_pulses), 32'(p0));
        txn(32'h300, 32'd0, 4'h0, 1'b0, rd, lat, exp_rd, known);
        check("abort_0x300", rd, 32'h1111_1111);

        // Fetch counting.
        for (int i = 0; i < 5; i++) txn(32'(4 * i), 32'd0, 4'h0, 1'b1, rd, lat, exp_rd, known);
        for (int i = 0; i < 3; i++) txn(32'(4 * i), 32'd0, 4'h0, 1'b0, rd, lat, exp_rd, known);
        txn(32'h40, 32'h5, 4'hF, 1'b1, rd, lat, exp_rd, known);
        check("fetch_count_5", fetch_count, 32'd5);

        // Randomized traffic against the reference model.
        con_mode = 2;
        for (int w = 0; w < 64; w++) txn(32'(4 * w), $urandom, 4'hF, 1'b0, rd, lat, exp_rd, known);
        for (int n = 0; n < 300; n++) begin
            kind = $urandom_range(0, 9);
            wd   = $urandom;
            ws   = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            ins  = (ws == 4'h0) ? 1'($urandom_range(0, 1)) : 1'b0;
            if (kind <= 5)      a = 32'($urandom_range(0, 63) * 4 + $urandom_range(0, 3));
            else if (kind <= 7) a = CON + 32'($urandom_range(0, 3));
            else if (kind == 8) a = EXA;
            else                a = 32'((MEM_WORDS + $urandom_range(0, 1000)) * 4);
            txn(a, wd, ws, ins, rd, lat, exp_rd, known);
            if (ws == 4'h0 && known) check("rnd_rdata", rd, exp_rd);
            if (!(kind inside {6, 7}) || ws == 4'h0) check("rnd_latency", 32'(lat), 32'(WS + 1));
            check("rnd_err", 32'(err), 32'(ref_err));
            check("rnd_exit_valid", 32'(exit_valid), 32'(ref_exit_valid));
            check("rnd_exit_code", exit_code, ref_exit_code);
            check("rnd_fetch", fetch_count, ref_fetch);
        end
        con_mode = 1;
        wait_drain("rnd_drain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_sim_port.md
Name: mem_sim_port

Overview:
- Parametrised simulation/FPGA memory responder for the core's native memory bus (mem_valid/mem_ready handshake).
- Successor to the fixed zero-wait, always-ready bench memory. Adds:
  - configurable wait states
  - word-organised storage with byte strobes
  - a back-pressured console FIFO
  - an exit register and an out-of-range error flag
- Sits between the core under test and the bench/FPGA top.

Parameters:
- MEM_WORDS, 65536: storage depth in 32-bit words (power of two).
- WAIT_STATES, 1: cycles between request acceptance and mem_ready (0..15).
- CONSOLE_ADDR, 32'h1000_0000: byte write here pushes wdata[7:0] to the console FIFO.
- EXIT_ADDR, 32'h2000_0000: write here latches exit_code.
- FIFO_DEPTH, 8: console FIFO entries (power of two, >=2).

Ports:
- clk  in  1  clock, all logic on rising edge.
- resetn  in  1  asynchronous active-low reset.
- mem_valid  in  1  request valid, held until mem_ready.
- mem_instr  in  1  instruction fetch qualifier (informational, counted only).
- mem_addr  in  32  byte address; bits [1:0] ignored.
- mem_wdata  in  32  write data.
- mem_wstrb  in  4  byte enables; 0 = read.
- mem_ready  out  1  one-cycle completion pulse.
- mem_rdata  out  32  read data, valid when mem_ready=1.
- con_data  out  8  console FIFO head byte.
- con_valid  out  1  console FIFO not empty.
- con_ready  in  1  consumer pops the head when con_valid&con_ready.
- exit_valid  out  1  sticky: exit register was written.
- exit_code  out  32  value written to EXIT_ADDR.
- err  out  1  sticky: access outside memory range, not a console/exit address.
- fetch_count  out  32  number of completed mem_instr reads.

Behaviour:
- Reset is asynchronous, applied on resetn low. Reset values: FSM=IDLE, mem_ready=0, mem_rdata=0, FIFO empty (con_valid=0, con_data=0), exit_valid=0, exit_code=0, err=0, fetch_count=0. Storage contents are not reset.
- FSM states IDLE, WAIT, RESP:
  - IDLE: mem_valid=1 latches addr/wdata/wstrb/instr and loads cnt=WAIT_STATES. Next state is WAIT if WAIT_STATES>0, else RESP.
  - WAIT: cnt decrements each cycle. At cnt==1, go to RESP.
  - RESP: mem_ready=1 for exactly one cycle, then IDLE.
  - Request-to-ready latency is WAIT_STATES+1 cycles. Back-to-back requests: a new mem_valid is sampled in IDLE, so there is at least one idle cycle between responses.
- Reads:
  - In range (word index < MEM_WORDS): mem_rdata=storage[addr[31:2]] on the RESP cycle.
  - Console or exit address: mem_rdata=0.
  - Otherwise: mem_rdata=32'hDEAD_BEEF and err set.
- Writes: the storage update is performed in the RESP cycle, per strobe bit; strobe bit i writes byte i.
  - Out-of-range write: dropped, err set.
  - Write to CONSOLE_ADDR: requires wstrb[0]. If the FIFO is full on entry to RESP, the FSM holds in WAIT (mem_ready stays 0) until a pop frees space. The byte is pushed on the RESP cycle.
  - Write to EXIT_ADDR: exit_code<=wdata and exit_valid<=1 on the RESP cycle. A later write overwrites exit_code; exit_valid stays 1.
- Console FIFO:
  - Pointer-based with log2(FIFO_DEPTH)+1-bit pointers; full/empty are determined by the MSB compare.
  - Push and pop in the same cycle while full: the pop is taken, and the push is permitted because the hold logic compares against the post-pop count.
  - Pointers wrap modulo 2*FIFO_DEPTH.
- fetch_count increments on RESP when the latched instr=1 and wstrb=0; it wraps at 2^32.
- mem_valid dropping mid-transaction is a protocol violation; the transaction still completes.
- Asynchronous reset mid-transaction aborts it; no write is committed.

Optional Feature:
- Macro MEMSIM_RANDOM_STALL_EN.
- Defined: a 16-bit Fibonacci LFSR (taps 16,14,13,11, seed 16'hACE1 at reset) advances every cycle. Each transaction adds lfsr[1:0] extra wait cycles, sampled at acceptance, so latency becomes WAIT_STATES+1+lfsr[1:0].
- Not defined: latency is fixed at WAIT_STATES+1 and no LFSR is instantiated.

Test Plan:
- WAIT_STATES=2: write 32'h1234_5678 (wstrb=4'hF) to 0x100, then read 0x100 -> each mem_ready arrives 3 cycles after mem_valid; read returns 32'h1234_5678.
- Write 32'hAABB_CCDD to 0x200 with wstrb=4'b0101 over existing 0 -> read returns 32'h00BB_00DD.
- con_ready=0, FIFO_DEPTH=8: 9 byte writes 'A'..'I' to CONSOLE_ADDR -> 8 complete, the 9th stalls. Raise con_ready -> the 9th completes, and bytes drain in order 'A'..'I'.
- Write 32'h0000_002A to EXIT_ADDR -> exit_valid=1, exit_code=42; read of address MEM_WORDS*4 -> mem_rdata=32'hDEAD_BEEF, err=1.
- Assert resetn=0 during WAIT of a write to 0x300 -> mem_ready never pulses, 0x300 is unchanged, all outputs return to reset values immediately.
- 5 fetches (mem_instr=1) plus 3 data reads -> fetch_count=5.
